// File: rtl/br_fifo_pop_burst_rr_sched_pkg.sv
// Shared types and helpers for the burst round-robin FIFO pop scheduler.
// The grant rule tells the top level how to update the burst counter.
package br_fifo_pop_burst_rr_sched_pkg;

    typedef enum logic [1:0] {
        RuleNone   = 2'd0,
        RuleKeep   = 2'd1,
        RuleRotate = 2'd2,
        RuleSole   = 2'd3
    } grant_rule_e;

    // clog2 that never returns 0, so a single-entry index still has one bit.
    function automatic int clamped_clog2(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/br_fifo_pop_burst_rr_pick.sv
// Combinational grant pick: keep ptr while its burst lasts, else the next valid
// requester after ptr (rotate / priority-encode / un-rotate), else ptr alone.
module br_fifo_pop_burst_rr_pick
    import br_fifo_pop_burst_rr_sched_pkg::*;
#(
    parameter  int NumRequesters = 2,
    localparam int IdWidth       = clamped_clog2(NumRequesters)
) (
    input  logic [NumRequesters-1:0] in_valid,
    input  logic [IdWidth-1:0]       ptr,
    input  logic                     burst_exhausted,
    output logic                     grant_valid,
    output logic [NumRequesters-1:0] grant,
    output logic [IdWidth-1:0]       grant_idx,
    output grant_rule_e              grant_rule
);

    localparam int SumWidth = IdWidth + 1;

    logic [NumRequesters-1:0]   others;
    logic [2*NumRequesters-1:0] doubled;
    logic [NumRequesters-1:0]   rotated;
    logic [SumWidth-1:0]        shamt;
    logic [SumWidth-1:0]        enc;
    logic [SumWidth-1:0]        unrot;
    logic                       other_any;
    logic                       own_valid;

    // NOTE: every signal written in an always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        others      = in_valid;
        others[ptr] = 1'b0;
        own_valid   = in_valid[ptr];

        // Rotate so that bit 0 is requester ptr+1; ptr itself lands in the top bit and is already cleared.
        shamt   = SumWidth'(ptr) + SumWidth'(1);
        doubled = {others, others};
        rotated = NumRequesters'(doubled >> shamt);

        enc = '0;
        for (int j = NumRequesters - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                enc = SumWidth'(j);
            end
        end
        other_any = |rotated;

        unrot = shamt + enc;
        if (unrot >= SumWidth'(NumRequesters)) begin
            unrot = unrot - SumWidth'(NumRequesters);
        end

        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_rule  = RuleNone;
        if (own_valid && !burst_exhausted) begin
            grant_valid = 1'b1;
            grant_idx   = ptr;
            grant_rule  = RuleKeep;
        end else if (other_any) begin
            grant_valid = 1'b1;
            grant_idx   = unrot[IdWidth-1:0];
            grant_rule  = RuleRotate;
        end else if (own_valid) begin
            grant_valid = 1'b1;
            grant_idx   = ptr;
            grant_rule  = RuleSole;
        end

        grant            = '0;
        grant[grant_idx] = grant_valid;
    end

endmodule

// File: rtl/br_fifo_pop_burst_rr_sched.sv
// Shares one registered output stage between several FIFO pop interfaces using
// round-robin arbitration with a per-requester burst allowance of MaxBurst pops.
module br_fifo_pop_burst_rr_sched
    import br_fifo_pop_burst_rr_sched_pkg::*;
#(
    parameter  int NumRequesters = 2,
    parameter  int Width         = 8,
    parameter  int MaxBurst      = 4,
    localparam int IdWidth       = clamped_clog2(NumRequesters),
    localparam int BurstWidth    = $clog2(MaxBurst + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NumRequesters-1:0]       in_valid,
    output logic [NumRequesters-1:0]       in_ready,
    input  logic [NumRequesters*Width-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [Width-1:0]               out_data,
    output logic [IdWidth-1:0]             out_id,
    output logic [BurstWidth-1:0]          burst_count
);

    logic                  out_valid_q, out_valid_d;
    logic [Width-1:0]      out_data_q, out_data_d;
    logic [IdWidth-1:0]    out_id_q, out_id_d;
    logic [IdWidth-1:0]    ptr_q, ptr_d;
    logic [BurstWidth-1:0] burst_count_q, burst_count_d;

    logic                     load;
    logic                     burst_exhausted;
    logic                     grant_valid;
    logic [NumRequesters-1:0] grant;
    logic [IdWidth-1:0]       grant_idx;
    grant_rule_e              grant_rule;

    assign burst_exhausted = (burst_count_q >= BurstWidth'(MaxBurst));
    assign load            = !out_valid_q || out_ready;
    // Nothing is popped while reset is asserted, so an upstream FIFO never loses an entry to reset.
    assign in_ready        = (rst_n && load) ? grant : '0;

    br_fifo_pop_burst_rr_pick #(
        .NumRequesters(NumRequesters)
    ) u_pick (
        .in_valid       (in_valid),
        .ptr            (ptr_q),
        .burst_exhausted(burst_exhausted),
        .grant_valid    (grant_valid),
        .grant          (grant),
        .grant_idx      (grant_idx),
        .grant_rule     (grant_rule)
    );

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_id_d      = out_id_q;
        ptr_d         = ptr_q;
        burst_count_d = burst_count_q;
        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = in_data[int'(grant_idx)*Width +: Width];
                out_id_d   = grant_idx;
                if (grant_rule == RuleKeep) begin
                    burst_count_d = burst_count_q + BurstWidth'(1);
                end else begin
                    ptr_d         = grant_idx;
                    burst_count_d = BurstWidth'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_id_q      <= '0;
            ptr_q         <= '0;
            burst_count_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_id_q      <= out_id_d;
            ptr_q         <= ptr_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_id      = out_id_q;
    assign burst_count = burst_count_q;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));
    a_burst_bound:   assert property (@(posedge clk) disable iff (!rst_n) burst_count_q <= BurstWidth'(MaxBurst));
    a_ptr_range:     assert property (@(posedge clk) disable iff (!rst_n) int'(ptr_q) < NumRequesters);
    a_out_stable:    assert property (@(posedge clk) disable iff (!rst_n)
                         (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q) && $stable(out_id_q)));

    // A requester held valid may be passed over in at most (N-1)*MaxBurst load cycles.
    localparam int StarveBound = (NumRequesters - 1) * MaxBurst;
    localparam int WaitWidth   = $clog2(StarveBound + 2);

    for (genvar i = 0; i < NumRequesters; i++) begin : g_starve
        logic [WaitWidth-1:0] wait_q;
        always_ff @(posedge clk) begin
            if (!rst_n || !in_valid[i] || in_ready[i]) begin
                wait_q <= '0;
            end else if (load) begin
                wait_q <= wait_q + WaitWidth'(1);
            end
        end
        a_no_starve: assert property (@(posedge clk) disable iff (!rst_n) wait_q <= WaitWidth'(StarveBound));
    end

endmodule

// File: tb/tb_br_fifo_pop_burst_rr_sched.sv
// Directed bench for the burst round-robin scheduler: a 2-requester instance driven
// from a vector table, plus a 4-requester instance for the wrapping search.
module tb_br_fifo_pop_burst_rr_sched;

    logic clk;
    logic rst_n;

    // 2 requesters, MaxBurst 4
    logic [1:0]  iv2;
    logic [1:0]  rdy2;
    logic [15:0] data2;
    logic        ov2;
    logic        ordy2;
    logic [7:0]  od2;
    logic        oid2;
    logic [2:0]  bc2;

    // 4 requesters, MaxBurst 2
    logic [3:0]  iv4;
    logic [3:0]  rdy4;
    logic [31:0] data4;
    logic        ov4;
    logic        ordy4;
    logic [7:0]  od4;
    logic [1:0]  oid4;
    logic [1:0]  bc4;

    int n_cmp  = 0;
    int n_fail = 0;

    br_fifo_pop_burst_rr_sched #(.NumRequesters(2), .Width(8), .MaxBurst(4)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv2),
        .in_ready   (rdy2),
        .in_data    (data2),
        .out_valid  (ov2),
        .out_ready  (ordy2),
        .out_data   (od2),
        .out_id     (oid2),
        .burst_count(bc2)
    );

    br_fifo_pop_burst_rr_sched #(.NumRequesters(4), .Width(8), .MaxBurst(2)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (iv4),
        .in_ready   (rdy4),
        .in_data    (data4),
        .out_valid  (ov4),
        .out_ready  (ordy4),
        .out_data   (od4),
        .out_id     (oid4),
        .burst_count(bc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] iv;
        logic       ordy;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] e_rdy;
        logic       e_ov;
        logic       e_id;
        logic [7:0] e_data;
        logic [2:0] e_bc;
    } vec_t;

    localparam int NumVecs = 28;
    vec_t vecs[NumVecs];

    function automatic vec_t mk(input logic [1:0] iv, input logic ordy, input logic [7:0] d0,
                                input logic [7:0] d1, input logic [1:0] e_rdy, input logic e_ov,
                                input logic e_id, input logic [7:0] e_data, input logic [2:0] e_bc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.d0 = d0; v.d1 = d1;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_id = e_id; v.e_data = e_data; v.e_bc = e_bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step4(input int n, input logic [3:0] iv, input logic [3:0] e_rdy,
                         input logic [1:0] e_id, input logic [7:0] e_data, input logic [1:0] e_bc);
        iv4 = iv;
        #1;
        check($sformatf("w%0d in_ready", n), 32'(rdy4), 32'(e_rdy));
        tick();
        check($sformatf("w%0d out_valid", n), 32'(ov4), 32'd1);
        check($sformatf("w%0d out_id", n), 32'(oid4), 32'(e_id));
        check($sformatf("w%0d out_data", n), 32'(od4), 32'(e_data));
        check($sformatf("w%0d burst_count", n), 32'(bc4), 32'(e_bc));
    endtask

    initial begin
        // Requester 0 heads use 0x0n / 0xA5, requester 1 heads use 0x8n; each head changes only after it is popped.
        vecs[0]  = mk(2'b11, 1'b1, 8'h01, 8'h81, 2'b01, 1'b1, 1'b0, 8'h01, 3'd1);
        vecs[1]  = mk(2'b11, 1'b1, 8'h02, 8'h81, 2'b01, 1'b1, 1'b0, 8'h02, 3'd2);
        vecs[2]  = mk(2'b11, 1'b1, 8'h03, 8'h81, 2'b01, 1'b1, 1'b0, 8'h03, 3'd3);
        vecs[3]  = mk(2'b11, 1'b1, 8'h04, 8'h81, 2'b01, 1'b1, 1'b0, 8'h04, 3'd4);
        vecs[4]  = mk(2'b11, 1'b1, 8'hA5, 8'h81, 2'b10, 1'b1, 1'b1, 8'h81, 3'd1);
        vecs[5]  = mk(2'b11, 1'b1, 8'hA5, 8'h82, 2'b10, 1'b1, 1'b1, 8'h82, 3'd2);
        vecs[6]  = mk(2'b11, 1'b1, 8'hA5, 8'h83, 2'b10, 1'b1, 1'b1, 8'h83, 3'd3);
        vecs[7]  = mk(2'b11, 1'b1, 8'hA5, 8'h84, 2'b10, 1'b1, 1'b1, 8'h84, 3'd4);
        vecs[8]  = mk(2'b11, 1'b1, 8'hA5, 8'h85, 2'b01, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[9]  = mk(2'b11, 1'b0, 8'h06, 8'h85, 2'b00, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[10] = mk(2'b11, 1'b0, 8'h06, 8'h85, 2'b00, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[11] = mk(2'b11, 1'b0, 8'h06, 8'h85, 2'b00, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[12] = mk(2'b11, 1'b0, 8'h06, 8'h85, 2'b00, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[13] = mk(2'b11, 1'b0, 8'h06, 8'h85, 2'b00, 1'b1, 1'b0, 8'hA5, 3'd1);
        vecs[14] = mk(2'b11, 1'b1, 8'h06, 8'h85, 2'b01, 1'b1, 1'b0, 8'h06, 3'd2);
        vecs[15] = mk(2'b10, 1'b1, 8'h00, 8'h85, 2'b10, 1'b1, 1'b1, 8'h85, 3'd1);
        vecs[16] = mk(2'b10, 1'b1, 8'h00, 8'h86, 2'b10, 1'b1, 1'b1, 8'h86, 3'd2);
        vecs[17] = mk(2'b10, 1'b1, 8'h00, 8'h87, 2'b10, 1'b1, 1'b1, 8'h87, 3'd3);
        vecs[18] = mk(2'b10, 1'b1, 8'h00, 8'h88, 2'b10, 1'b1, 1'b1, 8'h88, 3'd4);
        vecs[19] = mk(2'b10, 1'b1, 8'h00, 8'h89, 2'b10, 1'b1, 1'b1, 8'h89, 3'd1);
        vecs[20] = mk(2'b10, 1'b1, 8'h00, 8'h8A, 2'b10, 1'b1, 1'b1, 8'h8A, 3'd2);
        vecs[21] = mk(2'b10, 1'b1, 8'h00, 8'h8B, 2'b10, 1'b1, 1'b1, 8'h8B, 3'd3);
        vecs[22] = mk(2'b10, 1'b1, 8'h00, 8'h8C, 2'b10, 1'b1, 1'b1, 8'h8C, 3'd4);
        vecs[23] = mk(2'b10, 1'b1, 8'h00, 8'h8D, 2'b10, 1'b1, 1'b1, 8'h8D, 3'd1);
        vecs[24] = mk(2'b10, 1'b1, 8'h00, 8'h8E, 2'b10, 1'b1, 1'b1, 8'h8E, 3'd2);
        vecs[25] = mk(2'b00, 1'b1, 8'h07, 8'h8F, 2'b00, 1'b0, 1'b0, 8'h00, 3'd2);
        vecs[26] = mk(2'b01, 1'b1, 8'h07, 8'h8F, 2'b01, 1'b1, 1'b0, 8'h07, 3'd1);
        vecs[27] = mk(2'b11, 1'b1, 8'h08, 8'h8F, 2'b01, 1'b1, 1'b0, 8'h08, 3'd2);

        // Reset held for several cycles with both requesters valid.
        rst_n = 1'b0;
        iv2   = 2'b11;
        ordy2 = 1'b1;
        data2 = 16'h8101;
        iv4   = 4'b0000;
        ordy4 = 1'b1;
        data4 = {8'h33, 8'h32, 8'h31, 8'h30};
        tick();
        for (int r = 0; r < 3; r++) begin
            check($sformatf("rst%0d out_valid", r), 32'(ov2), 32'd0);
            check($sformatf("rst%0d in_ready", r), 32'(rdy2), 32'd0);
            check($sformatf("rst%0d out_id", r), 32'(oid2), 32'd0);
            check($sformatf("rst%0d burst_count", r), 32'(bc2), 32'd0);
            check($sformatf("rst%0d out_data", r), 32'(od2), 32'd0);
            tick();
        end
        rst_n = 1'b1;

        // Burst rotation, backpressure, sole requester, idle and recovery.
        for (int i = 0; i < NumVecs; i++) begin
            iv2   = vecs[i].iv;
            ordy2 = vecs[i].ordy;
            data2 = {vecs[i].d1, vecs[i].d0};
            #1;
            check($sformatf("v%0d in_ready", i), 32'(rdy2), 32'(vecs[i].e_rdy));
            tick();
            check($sformatf("v%0d out_valid", i), 32'(ov2), 32'(vecs[i].e_ov));
            check($sformatf("v%0d burst_count", i), 32'(bc2), 32'(vecs[i].e_bc));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d out_id", i), 32'(oid2), 32'(vecs[i].e_id));
                check($sformatf("v%0d out_data", i), 32'(od2), 32'(vecs[i].e_data));
            end
        end

        // Hold the 2-requester output (valid, burst 2) under backpressure while the 4-requester wrap runs.
        ordy2 = 1'b0;
        step4(0, 4'b1000, 4'b1000, 2'd3, 8'h33, 2'd1);
        step4(1, 4'b1000, 4'b1000, 2'd3, 8'h33, 2'd2);
        step4(2, 4'b1010, 4'b0010, 2'd1, 8'h31, 2'd1);
        step4(3, 4'b1010, 4'b0010, 2'd1, 8'h31, 2'd2);
        step4(4, 4'b1010, 4'b1000, 2'd3, 8'h33, 2'd1);
        iv4 = 4'b0000;
        check("held out_valid", 32'(ov2), 32'd1);
        check("held out_data", 32'(od2), 32'h08);
        check("held burst_count", 32'(bc2), 32'd2);

        // Reset mid-burst: the held entry is dropped and no pop happens during reset.
        ordy2 = 1'b1;
        iv2   = 2'b11;
        data2 = 16'h8F09;
        rst_n = 1'b0;
        #1;
        check("midrst in_ready", 32'(rdy2), 32'd0);
        tick();
        check("midrst out_valid", 32'(ov2), 32'd0);
        check("midrst burst_count", 32'(bc2), 32'd0);
        check("midrst out_id", 32'(oid2), 32'd0);
        check("midrst out_data", 32'(od2), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post in_ready", 32'(rdy2), 32'b01);
        tick();
        check("post out_valid", 32'(ov2), 32'd1);
        check("post out_id", 32'(oid2), 32'd0);
        check("post out_data", 32'(od2), 32'h09);
        check("post burst_count", 32'(bc2), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
